ctrl_pipe: RTL and testbench

Control-signal pipeline for the 5-stage RV32I core. It captures the decode-stage control word produced by the controller and carries it through the E, M and W stages. In E it resolves branches and jumps against the ALU flags and produces the PC-select signals. It sits between the controller and the datapath/hazard unit, and replaces ad-hoc control flops in the datapath.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/ctrl_stage_reg.sv | 24 ++
 rtl/ctrl_pipe.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core control path.
// Holds opcode and branch funct3 constants plus the packed control words
// carried by the E, M and W pipeline stages.
package core_pkg;

  // Opcodes
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  // Branch funct3 encodings
  localparam logic [2:0] BEQ = 3'b000;
  localparam logic [2:0] BNE = 3'b001;
  localparam logic [2:0] BLT = 3'b100;
  localparam logic [2:0] BGE = 3'b101;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
    logic       aluSrc;
    logic       jump;
    logic       branch;
    logic [2:0] funct3;
    logic       jalr;
  } ctrl_e_t;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
  } ctrl_m_t;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic [1:0] resultSrc;
  } ctrl_w_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Pipeline stage register for control words.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q
//   clr   - synchronous clear (loads all zeros, i.e. a bubble)
//   d     - next control word
//   q     - registered control word
module ctrl_stage_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline for the 5-stage RV32I core.
// Carries the decode-stage control word through E, M and W, resolves
// branches/jumps in E and counts instructions retiring from W.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   ValidD, opD, funct3D, *D controls  - decode-stage control word
//   FlushE                             - bubble the D->E load
//   ZeroE, LessThanE                   - ALU flags for the E instruction
//   *E / *M / *W outputs               - stage control fields
//   PCSrcE, PCTargetSrcE               - PC redirect and target select
//   RetiredW                           - wrapping retired-instruction count
module ctrl_pipe
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidD,
  input  logic [6:0]       opD,
  input  logic [2:0]       funct3D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             FlushE,
  input  logic             ZeroE,
  input  logic             LessThanE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic             RegWriteE,
  output logic             PCSrcE,
  output logic             PCTargetSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [CNT_W-1:0] RetiredW
);

  ctrl_e_t dE, qE;
  ctrl_m_t dM, qM;
  ctrl_w_t dW, qW;
  logic    clrE;
  logic    branchCond;
  logic [CNT_W-1:0] retiredCnt;

  // Invalid D words are squashed to zero so every E field of a bubble is 0.
  assign clrE = FlushE | ~ValidD;

  always_comb begin
    dE            = '0;
    dE.valid      = ValidD;
    dE.regWrite   = RegWriteD;
    dE.memWrite   = MemWriteD;
    dE.resultSrc  = ResultSrcD;
    dE.aluControl = ALUControlD;
    dE.aluSrc     = ALUSrcD;
    dE.jump       = JumpD;
    dE.branch     = BranchD;
    dE.funct3     = funct3D;
    dE.jalr       = (opD == JALR);
  end

  always_comb begin
    dM           = '0;
    dM.valid     = qE.valid;
    dM.regWrite  = qE.regWrite;
    dM.memWrite  = qE.memWrite;
    dM.resultSrc = qE.resultSrc;
  end

  always_comb begin
    dW           = '0;
    dW.valid     = qM.valid;
    dW.regWrite  = qM.regWrite;
    dW.resultSrc = qM.resultSrc;
  end

  ctrl_stage_reg #(.W($bits(ctrl_e_t))) eReg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clrE),
    .d    (dE),
    .q    (qE)
  );

  ctrl_stage_reg #(.W($bits(ctrl_m_t))) mReg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .d    (dM),
    .q    (qM)
  );

  ctrl_stage_reg #(.W($bits(ctrl_w_t))) wReg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .d    (dW),
    .q    (qW)
  );

  // Signed compare flags from the ALU; unsupported funct3 never branches.
  always_comb begin
    branchCond = 1'b0;
    case (qE.funct3)
      BEQ:     branchCond = ZeroE;
      BNE:     branchCond = ~ZeroE;
      BLT:     branchCond = LessThanE;
      BGE:     branchCond = ~LessThanE;
      default: branchCond = 1'b0;
    endcase
  end

  assign PCSrcE       = qE.valid & (qE.jump | (qE.branch & branchCond));
  assign PCTargetSrcE = qE.valid & qE.jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retiredCnt <= '0;
    else if (qW.valid) retiredCnt <= retiredCnt + CNT_W'(1);
  end

  assign ALUControlE = qE.aluControl;
  assign ALUSrcE     = qE.aluSrc;
  assign ResultSrcE  = qE.resultSrc;
  assign RegWriteE   = qE.regWrite;
  assign RegWriteM   = qM.regWrite;
  assign MemWriteM   = qM.memWrite;
  assign ResultSrcM  = qM.resultSrc;
  assign RegWriteW   = qW.regWrite;
  assign ResultSrcW  = qW.resultSrc;
  assign RetiredW    = retiredCnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ValidD, RegWriteD, MemWriteD, ALUSrcD, JumpD, BranchD;
  logic [6:0]    opD;
  logic [2:0]    funct3D, ALUControlD;
  logic [1:0]    ResultSrcD;
  logic          FlushE, ZeroE, LessThanE;
  logic [2:0]    ALUControlE;
  logic          ALUSrcE, RegWriteE, PCSrcE, PCTargetSrcE;
  logic [1:0]    ResultSrcE, ResultSrcM, ResultSrcW;
  logic          RegWriteM, MemWriteM, RegWriteW;
  logic [CW-1:0] RetiredW;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .opD(opD), .funct3D(funct3D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .FlushE(FlushE), .ZeroE(ZeroE),
    .LessThanE(LessThanE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
    .PCTargetSrcE(PCTargetSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RetiredW(RetiredW)
  );

  // Reference model: an instruction record per stage (0=E, 1=M, 2=W).
  typedef struct {
    bit       valid;
    bit       rw;
    bit       mw;
    bit [1:0] rs;
    bit [2:0] alu;
    bit       as;
    bit       j;
    bit       b;
    bit [2:0] f3;
    bit       jalr;
  } word_t;

  word_t         pipe [3];
  word_t         nextLoad;
  word_t         zeroWord;
  bit [CW-1:0]   retiredExp;
  bit            zCur, ltCur;
  int            compareCount = 0;
  int            mismatchCount = 0;
  bit [CW-1:0]   saved;
  bit [6:0]      opTable [8];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit taken(input bit [2:0] f3, input bit z, input bit lt);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkAll();
    word_t e, m, w;
    e = pipe[0]; m = pipe[1]; w = pipe[2];
    checkVal("ALUControlE", 32'(ALUControlE), 32'(e.alu));
    checkVal("ALUSrcE", 32'(ALUSrcE), 32'(e.as));
    checkVal("ResultSrcE", 32'(ResultSrcE), 32'(e.rs));
    checkVal("RegWriteE", 32'(RegWriteE), 32'(e.rw));
    checkVal("PCSrcE", 32'(PCSrcE), 32'(e.valid && (e.j || (e.b && taken(e.f3, zCur, ltCur)))));
    checkVal("PCTargetSrcE", 32'(PCTargetSrcE), 32'(e.valid && e.jalr));
    checkVal("RegWriteM", 32'(RegWriteM), 32'(m.rw));
    checkVal("MemWriteM", 32'(MemWriteM), 32'(m.mw));
    checkVal("ResultSrcM", 32'(ResultSrcM), 32'(m.rs));
    checkVal("RegWriteW", 32'(RegWriteW), 32'(w.rw));
    checkVal("ResultSrcW", 32'(ResultSrcW), 32'(w.rs));
    checkVal("RetiredW", 32'(RetiredW), 32'(retiredExp));
  endtask

  // Drive one D-stage word plus E flags, then check all outputs.
  task automatic apply(input bit vD, input bit [6:0] op, input bit [2:0] f3,
                       input bit rw, input bit mw, input bit as, input bit j,
                       input bit b, input bit [1:0] rs, input bit [2:0] alu,
                       input bit flush, input bit z, input bit lt);
    ValidD = vD; opD = op; funct3D = f3; RegWriteD = rw; MemWriteD = mw;
    ALUSrcD = as; JumpD = j; BranchD = b; ResultSrcD = rs; ALUControlD = alu;
    FlushE = flush; ZeroE = z; LessThanE = lt;
    zCur = z; ltCur = lt;
    if (flush || !vD) nextLoad = zeroWord;
    else begin
      nextLoad.valid = 1'b1; nextLoad.rw = rw; nextLoad.mw = mw; nextLoad.rs = rs;
      nextLoad.alu = alu; nextLoad.as = as; nextLoad.j = j; nextLoad.b = b;
      nextLoad.f3 = f3; nextLoad.jalr = (op == 7'b1100111);
    end
    #1;
    checkAll();
  endtask

  task automatic idle(input bit z, input bit lt);
    apply(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, z, lt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (pipe[2].valid) retiredExp = retiredExp + 1'b1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nextLoad;
    @(negedge clk);
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = zeroWord;
    nextLoad = zeroWord;
    retiredExp = '0;
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomStep();
    bit [6:0] op;
    op = opTable[$urandom_range(0, 7)];
    apply(($urandom_range(0, 9) < 8), op, 3'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
          ($urandom_range(0, 9) < 2), 1'($urandom), 1'($urandom));
    tick();
  endtask

  initial begin
    int brTab [8][4];
    opTable[0] = 7'b0000011; opTable[1] = 7'b0100011; opTable[2] = 7'b0010011;
    opTable[3] = 7'b0110011; opTable[4] = 7'b1100011; opTable[5] = 7'b1101111;
    opTable[6] = 7'b1100111; opTable[7] = 7'($urandom);
    zeroWord = '{default: '0};
    zCur = 0; ltCur = 0;
    ValidD = 0; opD = 0; funct3D = 0; RegWriteD = 0; MemWriteD = 0; ALUSrcD = 0;
    JumpD = 0; BranchD = 0; ResultSrcD = 0; ALUControlD = 0; FlushE = 0;
    ZeroE = 0; LessThanE = 0;
    #2;
    doReset();

    // lw through the pipe
    apply(1, 7'b0000011, 3'b010, 1, 0, 1, 0, 0, 2'b01, 3'b000, 0, 0, 0);
    tick();
    idle(0, 0);
    checkVal("lw ResultSrcE+1", 32'(ResultSrcE), 32'd1);
    tick();
    idle(0, 0);
    checkVal("lw ResultSrcM+2", 32'(ResultSrcM), 32'd1);
    tick();
    idle(0, 0);
    checkVal("lw RegWriteW+3", 32'(RegWriteW), 32'd1);
    checkVal("lw ResultSrcW+3", 32'(ResultSrcW), 32'd1);
    checkVal("lw Retired before", 32'(RetiredW), 32'd0);
    tick();
    idle(0, 0);
    checkVal("lw Retired after", 32'(RetiredW), 32'd1);

    // branch table: funct3, Zero, LessThan, expected PCSrcE
    brTab = '{'{1, 0, 0, 1}, '{1, 1, 0, 0}, '{5, 0, 1, 0}, '{4, 1, 1, 1},
              '{2, 0, 0, 0}, '{2, 1, 1, 0}, '{0, 1, 0, 1}, '{5, 1, 0, 1}};
    for (int i = 0; i < 8; i++) begin
      apply(1, 7'b1100011, 3'(brTab[i][0]), 0, 0, 0, 0, 1, 2'd0, 3'd1, 0, 0, 0);
      tick();
      idle(1'(brTab[i][1]), 1'(brTab[i][2]));
      checkVal($sformatf("branch%0d PCSrcE", i), 32'(PCSrcE), 32'(brTab[i][3]));
      checkVal($sformatf("branch%0d PCTargetSrcE", i), 32'(PCTargetSrcE), 32'd0);
      tick();
    end

    // jalr then jal
    apply(1, 7'b1100111, 3'b000, 1, 0, 1, 1, 0, 2'b10, 3'd0, 0, 0, 0);
    tick();
    apply(1, 7'b1101111, 3'b000, 1, 0, 0, 1, 0, 2'b10, 3'd0, 0, 1, 1);
    checkVal("jalr PCSrcE", 32'(PCSrcE), 32'd1);
    checkVal("jalr PCTargetSrcE", 32'(PCTargetSrcE), 32'd1);
    tick();
    idle(0, 0);
    checkVal("jal PCSrcE", 32'(PCSrcE), 32'd1);
    checkVal("jal PCTargetSrcE", 32'(PCTargetSrcE), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin idle(0, 0); tick(); end

    // flushed sw becomes a bubble
    saved = retiredExp;
    apply(1, 7'b0100011, 3'b010, 0, 1, 1, 0, 0, 2'b00, 3'd0, 1, 0, 0);
    tick();
    idle(0, 0);
    tick();
    idle(0, 0);
    checkVal("flush sw MemWriteM", 32'(MemWriteM), 32'd0);
    tick();
    idle(0, 0);
    tick();
    idle(0, 0);
    checkVal("flush sw RetiredW", 32'(RetiredW), 32'(saved));

    // flush in the same cycle as a taken beq: beq still retires
    apply(1, 7'b1100011, 3'b000, 0, 0, 0, 0, 1, 2'd0, 3'd1, 0, 0, 0);
    tick();
    apply(1, 7'b0010011, 3'b000, 1, 0, 1, 0, 0, 2'd0, 3'd0, 1, 1, 0);
    checkVal("flush+beq PCSrcE", 32'(PCSrcE), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin idle(0, 0); tick(); end
    idle(0, 0);
    checkVal("flush+beq RetiredW", 32'(RetiredW), 32'(saved + 1'b1));

    // reset while an addi sits in M
    for (int i = 0; i < 20; i++) randomStep();
    apply(1, 7'b0010011, 3'b000, 1, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 0);
    tick();
    idle(0, 0);
    tick();
    idle(0, 0);
    checkVal("addi in M", 32'(RegWriteM), 32'd1);
    doReset();
    checkVal("midreset RegWriteM", 32'(RegWriteM), 32'd0);
    checkVal("midreset RegWriteW", 32'(RegWriteW), 32'd0);
    checkVal("midreset RetiredW", 32'(RetiredW), 32'd0);

    // random traffic; long enough for the counter to wrap several times
    for (int i = 0; i < 1500; i++) randomStep();
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
